// File: rtl/load_pipe_chk_pkg.sv
// Shared types and constants for the load_pipe_chk checker.
// Pure definitions: no latency and no backpressure.
package load_pipe_chk_pkg;

  typedef enum int {
    MODE_FREE = 1,
    MODE_LOAD = 2
  } mode_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 1;

  function automatic logic [31:0] cnt_sat(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/load_pipe_chan.sv
// One checker channel: DEPTH-stage expected-value pipeline, comparator and saturating counter.
// Latency: d -> exp_q in DEPTH cycles, mismatch one cycle after the compare; no backpressure.
module load_pipe_chan
  import load_pipe_chk_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MODE      = MODE_FREE,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     dut_q,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     exp_q,
  output logic                 exp_vld,
  output logic                 mismatch,
  output logic                 hit,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] SAT = ERR_CNT_W'(cnt_sat(ERR_CNT_W));

  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic [DEPTH-1:0] stg_vld;
  logic             cap;

  // Free-running mode captures every cycle; load mode holds data between strobes.
  assign cap = (MODE == MODE_LOAD) ? load : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stg_dat[i] <= '0;
      stg_vld <= '0;
    end else begin
      if (cap) stg_dat[0] <= d;
      stg_vld[0] <= cap;
      for (int i = 1; i < DEPTH; i++) begin
        stg_dat[i] <= stg_dat[i-1];
        stg_vld[i] <= stg_vld[i-1];
      end
    end
  end

  assign exp_q   = stg_dat[DEPTH-1];
  assign exp_vld = stg_vld[DEPTH-1];

  // Case inequality so an X/Z on the DUT output is reported, not masked.
  assign hit = exp_vld && (dut_q !== exp_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      mismatch <= hit;
      if (err_clr)
        err_cnt <= hit ? ERR_CNT_W'(1) : '0;
      else if (hit && (err_cnt != SAT))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/load_pipe_chk.sv
// Multi-channel load-register reference checker; LOAD_PIPE_CHK_SVA_EN adds per-channel SVA.
// Latency: exp_q DEPTH cycles after d, mismatch/err_any one cycle after compare; no backpressure.
module load_pipe_chk
  import load_pipe_chk_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MODE      = MODE_FREE,
  parameter int ERR_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           load,
  input  logic [CHANNELS*WIDTH-1:0]     d,
  input  logic [CHANNELS*WIDTH-1:0]     dut_q,
  input  logic                          err_clr,
  output logic [CHANNELS*WIDTH-1:0]     exp_q,
  output logic [CHANNELS-1:0]           exp_vld,
  output logic [CHANNELS-1:0]           mismatch,
  output logic [CHANNELS*ERR_CNT_W-1:0] err_cnt,
  output logic                          err_any
);

  if (MODE != MODE_FREE && MODE != MODE_LOAD) begin : g_bad_mode
    $fatal(1, "load_pipe_chk: MODE must be 1 or 2");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "load_pipe_chk: DEPTH must be >= 1");
  end
  if (CHANNELS < 1) begin : g_bad_chan
    $fatal(1, "load_pipe_chk: CHANNELS must be >= 1");
  end

  logic [CHANNELS-1:0] hit;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    load_pipe_chan #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(MODE), .ERR_CNT_W(ERR_CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load[c]),
      .d        (d[c*WIDTH +: WIDTH]),
      .dut_q    (dut_q[c*WIDTH +: WIDTH]),
      .err_clr  (err_clr),
      .exp_q    (exp_q[c*WIDTH +: WIDTH]),
      .exp_vld  (exp_vld[c]),
      .mismatch (mismatch[c]),
      .hit      (hit[c]),
      .err_cnt  (err_cnt[c*ERR_CNT_W +: ERR_CNT_W])
    );
  end

  // A clear coincident with a fresh mismatch must leave the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      err_any <= 1'b0;
    else if (err_clr)  err_any <= |hit;
    else if (|hit)     err_any <= 1'b1;
  end

`ifdef LOAD_PIPE_CHK_SVA_EN
  localparam logic [ERR_CNT_W-1:0] SAT = ERR_CNT_W'(cnt_sat(ERR_CNT_W));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sva
    if (MODE == MODE_FREE) begin : g_free
      a_free: assert property (@(posedge clk) disable iff (!reset_n)
        exp_vld[c] |-> dut_q[c*WIDTH +: WIDTH] == $past(d[c*WIDTH +: WIDTH], DEPTH));
    end else begin : g_load
      a_load: assert property (@(posedge clk) disable iff (!reset_n)
        load[c] |-> ##DEPTH dut_q[c*WIDTH +: WIDTH] == $past(d[c*WIDTH +: WIDTH], DEPTH));
    end
    c_sat: cover property (@(posedge clk) disable iff (!reset_n)
      err_cnt[c*ERR_CNT_W +: ERR_CNT_W] == SAT);
  end
`endif

endmodule

// File: tb/tb_load_pipe_chk.sv
// Bench for load_pipe_chk: three configurations share stimulus, each scored against a history model.
module tb_load_pipe_chk;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  load;
  logic [31:0] d;
  logic        err_clr;
  logic [31:0] dq [NI];
  logic [31:0] oq [NI];
  logic [1:0]  ov [NI];
  logic [1:0]  om [NI];
  logic        oa [NI];
  logic [7:0]  cnt_a;
  logic [15:0] cnt_b, cnt_c;

  always #5 clk = ~clk;

  // a: free-running, DEPTH 3, 4-bit counters; b: load-gated, DEPTH 2; c: free-running, DEPTH 1
  load_pipe_chk #(.WIDTH(16), .CHANNELS(2), .DEPTH(3), .MODE(1), .ERR_CNT_W(4)) u_a (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .dut_q(dq[0]), .err_clr(err_clr),
    .exp_q(oq[0]), .exp_vld(ov[0]), .mismatch(om[0]), .err_cnt(cnt_a), .err_any(oa[0]));
  load_pipe_chk #(.WIDTH(16), .CHANNELS(2), .DEPTH(2), .MODE(2), .ERR_CNT_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .dut_q(dq[1]), .err_clr(err_clr),
    .exp_q(oq[1]), .exp_vld(ov[1]), .mismatch(om[1]), .err_cnt(cnt_b), .err_any(oa[1]));
  load_pipe_chk #(.WIDTH(16), .CHANNELS(2), .DEPTH(1), .MODE(1), .ERR_CNT_W(8)) u_c (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .dut_q(dq[2]), .err_clr(err_clr),
    .exp_q(oq[2]), .exp_vld(ov[2]), .mismatch(om[2]), .err_cnt(cnt_c), .err_any(oa[2]));

  // Model state: per-edge history of d/load since reset, plus error bookkeeping.
  logic [31:0] hd_q [$];
  logic [1:0]  hl_q [$];
  int          m_cnt [NI][2];
  logic [1:0]  m_mis [NI];
  logic        m_any [NI];
  logic [31:0] cmask [NI];
  logic        xinj;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int depth_of(input int i);
    case (i) 0: return 3; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int mode_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int sat_of(input int i);
    return (i == 0) ? 15 : 255;
  endfunction
  function automatic logic [31:0] cnt_of(input int i, input int ch);
    logic [31:0] r;
    case (i)
      0:       r = 32'(cnt_a[ch*4 +: 4]);
      1:       r = 32'(cnt_b[ch*8 +: 8]);
      default: r = 32'(cnt_c[ch*8 +: 8]);
    endcase
    return r;
  endfunction

  // Expected output after the latest recorded edge: the value d had DEPTH-1 edges earlier
  // (load mode: valid only if that edge loaded; data is the most recent load at or before it).
  task automatic model_exp(input int i, input int ch, output logic v, output logic [15:0] q);
    int j;
    logic [31:0] e;
    v = 1'b0;
    q = '0;
    j = hd_q.size() - depth_of(i);
    if (j >= 0) begin
      if (mode_of(i) == 1) begin
        v = 1'b1;
        e = hd_q[j];
        q = e[ch*16 +: 16];
      end else begin
        e = {30'd0, hl_q[j]};
        v = e[ch];
        for (int t = j; t >= 0; t--) begin
          e = {30'd0, hl_q[t]};
          if (e[ch]) begin
            e = hd_q[t];
            q = e[ch*16 +: 16];
            break;
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    hd_q.delete();
    hl_q.delete();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i][0] = 0;
      m_cnt[i][1] = 0;
      m_mis[i] = 2'b00;
      m_any[i] = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic v;
    logic [15:0] q;
    logic [31:0] eq;
    logic [1:0] ev;
    for (int i = 0; i < NI; i++) begin
      eq = '0;
      ev = '0;
      for (int ch = 0; ch < 2; ch++) begin
        model_exp(i, ch, v, q);
        eq[ch*16 +: 16] = q;
        ev[ch] = v;
        chk($sformatf("err_cnt[%0d][%0d]", i, ch), cnt_of(i, ch), 32'(m_cnt[i][ch]));
      end
      chk($sformatf("exp_q[%0d]", i), oq[i], eq);
      chk($sformatf("exp_vld[%0d]", i), 32'(ov[i]), 32'(ev));
      chk($sformatf("mismatch[%0d]", i), 32'(om[i]), 32'(m_mis[i]));
      chk($sformatf("err_any[%0d]", i), 32'(oa[i]), 32'(m_any[i]));
    end
  endtask

  // Called at a negedge with d/load/err_clr/reset_n already set: drives dut_q from the
  // model's current expectation (xor cmask), scores the coming edge, then checks after it.
  task automatic step();
    logic v, h;
    logic [15:0] q;
    logic [31:0] eq;
    logic [1:0] ev, hits;
    for (int i = 0; i < NI; i++) begin
      eq = '0;
      ev = '0;
      for (int ch = 0; ch < 2; ch++) begin
        model_exp(i, ch, v, q);
        eq[ch*16 +: 16] = q;
        ev[ch] = v;
      end
      dq[i] = eq ^ cmask[i];
      if (xinj && i == 0) dq[i][15:0] = 'x;
      hits = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        h = ev[ch] && (dq[i][ch*16 +: 16] !== eq[ch*16 +: 16]);
        hits[ch] = h;
        if (err_clr) m_cnt[i][ch] = h ? 1 : 0;
        else if (h && m_cnt[i][ch] < sat_of(i)) m_cnt[i][ch]++;
      end
      m_mis[i] = hits;
      m_any[i] = err_clr ? (|hits) : (m_any[i] || (|hits));
    end
    if (!reset_n) model_reset();
    else begin
      hd_q.push_back(d);
      hl_q.push_back(load);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic        ld0;
    logic [15:0] d0;
    logic        bv;
    logic [15:0] bq;
    logic [15:0] cq;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Edge k after reset: b loads ch0 only at edge 5, so exp_vld[0] only after edge 6.
    tbl[0] = '{1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1234};
    tbl[1] = '{1'b0, 16'h1234, 1'b0, 16'h0000, 16'h1234};
    tbl[2] = '{1'b0, 16'h5555, 1'b0, 16'h0000, 16'h5555};
    tbl[3] = '{1'b0, 16'hAAAA, 1'b0, 16'h0000, 16'hAAAA};
    tbl[4] = '{1'b1, 16'h00FF, 1'b0, 16'h0000, 16'h00FF};
    tbl[5] = '{1'b0, 16'h7777, 1'b1, 16'h00FF, 16'h7777};
    tbl[6] = '{1'b0, 16'h8888, 1'b0, 16'h00FF, 16'h8888};
    tbl[7] = '{1'b0, 16'h9999, 1'b0, 16'h00FF, 16'h9999};

    reset_n = 1'b0;
    load = 2'b00;
    d = '0;
    err_clr = 1'b0;
    xinj = 1'b0;
    for (int i = 0; i < NI; i++) begin
      cmask[i] = '0;
      dq[i] = '0;
    end
    model_reset();
    @(negedge clk);
    step();
    step();

    reset_n = 1'b1;
    foreach (tbl[k]) begin
      load = {1'b0, tbl[k].ld0};
      d = {16'hABCD, tbl[k].d0};
      step();
      chk("tbl_b_vld0", 32'(ov[1][0]), 32'(tbl[k].bv));
      chk("tbl_b_q0", 32'(oq[1][15:0]), 32'(tbl[k].bq));
      chk("tbl_c_vld", 32'(ov[2]), 32'h3);
      chk("tbl_c_q", oq[2], {16'hABCD, tbl[k].cq});
      chk("tbl_c_mis", 32'(om[2]), 32'h0);
      chk("tbl_c_any", 32'(oa[2]), 32'h0);
    end
    load = 2'b00;

    // a's ch1 expectation is 0xABCD here; the mask turns the DUT value into 0xDEAD.
    cmask[0] = {16'hABCD ^ 16'hDEAD, 16'h0000};
    step();
    chk("one_err_mis", 32'(om[0]), 32'h2);
    chk("one_err_cnt1", 32'(cnt_a[7:4]), 32'd1);
    chk("one_err_cnt0", 32'(cnt_a[3:0]), 32'd0);
    chk("one_err_any", 32'(oa[0]), 32'd1);
    cmask[0] = '0;
    step();
    chk("one_err_pulse_end", 32'(om[0]), 32'h0);
    chk("one_err_cnt_hold", 32'(cnt_a[7:4]), 32'd1);

    xinj = 1'b1;
    step();
    xinj = 1'b0;
    chk("x_is_mis", 32'(om[0][0]), 32'd1);
    chk("x_cnt0", 32'(cnt_a[3:0]), 32'd1);

    cmask[0] = 32'h0000_0001;
    repeat (20) step();
    chk("sat_cnt0", 32'(cnt_a[3:0]), 32'd15);
    err_clr = 1'b1;
    step();
    chk("clr_hit_cnt0", 32'(cnt_a[3:0]), 32'd1);
    chk("clr_hit_cnt1", 32'(cnt_a[7:4]), 32'd0);
    chk("clr_hit_any", 32'(oa[0]), 32'd1);
    cmask[0] = '0;
    step();
    chk("clr_any", 32'(oa[0]), 32'd0);
    chk("clr_cnt", 32'(cnt_a), 32'd0);
    err_clr = 1'b0;

    d = 32'h0F0F_F0F0;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("arst_exp_q[%0d]", i), oq[i], 32'h0);
      chk($sformatf("arst_vld[%0d]", i), 32'(ov[i]), 32'h0);
      chk($sformatf("arst_mis[%0d]", i), 32'(om[i]), 32'h0);
      chk($sformatf("arst_any[%0d]", i), 32'(oa[i]), 32'h0);
    end
    chk("arst_cnt_a", 32'(cnt_a), 32'h0);
    @(negedge clk);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmask[0] = $urandom | 32'h1;
      d = $urandom;
      step();
      chk("refill_no_mis", 32'(om[0]), 32'h0);
    end
    cmask[0] = '0;

    for (int n = 0; n < 600; n++) begin
      d = $urandom;
      load = 2'($urandom_range(0, 3));
      err_clr = ($urandom_range(0, 29) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NI; i++)
        cmask[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
